// File: rtl/fft_pkg.sv
// Shared definitions for the FFT output reorder buffer.
// Bit-reversal helper and read-FSM encoding.
package fft_pkg;

  localparam int FFT_N = 16;
  localparam int LOG2N = $clog2(FFT_N);

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

  function automatic logic [31:0] bitrev(
    input logic [31:0] value,
    input int          nbits
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nbits; i++) begin
      r[i] = value[nbits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// One ping-pong bank: N-deep register array,
// synchronous write, asynchronous read.
module fft_reorder_bank
  import fft_pkg::*;
#(
  parameter int DW    = 26,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge Clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for
// a radix-2 SDF FFT, built on two ping-pong banks.
module fft_reorder
  import fft_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int N     = 16
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    In_valid,
  input  logic signed [WIDTH-1:0] In_re,
  input  logic signed [WIDTH-1:0] In_im,
  output logic                    Out_valid,
  output logic signed [WIDTH-1:0] Out_re,
  output logic signed [WIDTH-1:0] Out_im,
  output logic [$clog2(N)-1:0]    Out_idx,
  output logic                    Out_last
);

  localparam int LW = $clog2(N);
  localparam int DW = 2 * WIDTH;
  localparam logic [LW-1:0] LASTC = LW'(N - 1);

  logic [LW-1:0] wcnt;
  logic          wsel;
  logic [LW-1:0] rcnt;
  logic [LW-1:0] rcnt_d;
  logic [LW-1:0] waddr;
  logic          rd_start;
  logic          rd_en;
  rd_state_t     state_q;
  rd_state_t     state_d;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
  logic [DW-1:0] rdata;

  assign rd_start = In_valid && (wcnt == LASTC);
  assign waddr    = LW'(bitrev(32'(wcnt), LW));
  assign wdata    = {In_re, In_im};

  fft_reorder_bank #(
    .DW    (DW),
    .DEPTH (N)
  ) u_bank0 (
    .Clk   (Clk),
    .we    (In_valid && !wsel),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt),
    .rdata (rd0)
  );

  fft_reorder_bank #(
    .DW    (DW),
    .DEPTH (N)
  ) u_bank1 (
    .Clk   (Clk),
    .we    (In_valid && wsel),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rcnt),
    .rdata (rd1)
  );

  // Read side always drains the bank not being written.
  assign rdata = wsel ? rd0 : rd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wcnt <= '0;
      wsel <= 1'b0;
    end else if (In_valid) begin
      wcnt <= wcnt + 1'b1;
      if (wcnt == LASTC) begin
        wsel <= ~wsel;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt;
    rd_en   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rd_start) begin
          state_d = READ;
          rcnt_d  = '0;
        end
      end
      READ: begin
        rd_en = 1'b1;
        if (rcnt == LASTC) begin
          rcnt_d  = '0;
          state_d = rd_start ? READ : IDLE;
        end else begin
          rcnt_d = rcnt + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      rcnt    <= '0;
    end else begin
      state_q <= state_d;
      rcnt    <= rcnt_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Out_valid <= 1'b0;
      Out_last  <= 1'b0;
      Out_re    <= '0;
      Out_im    <= '0;
      Out_idx   <= '0;
    end else if (rd_en) begin
      Out_valid <= 1'b1;
      Out_last  <= (rcnt == LASTC);
      Out_re    <= rdata[DW-1:WIDTH];
      Out_im    <= rdata[WIDTH-1:0];
      Out_idx   <= rcnt;
    end else begin
      Out_valid <= 1'b0;
      Out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_reorder.sv
// Directed bench for fft_reorder: table-driven frames
// plus gap, back-to-back, extreme and reset sequences.
module tb_fft_reorder;

  logic                     Clk = 1'b0;
  logic                     Reset;
  logic                     In_valid;
  logic signed [12:0]       In_re;
  logic signed [12:0]       In_im;
  logic                     Out_valid;
  logic signed [12:0]       Out_re;
  logic signed [12:0]       Out_im;
  logic [3:0]               Out_idx;
  logic                     Out_last;

  fft_reorder #(.WIDTH(13), .N(16)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .In_valid  (In_valid),
    .In_re     (In_re),
    .In_im     (In_im),
    .Out_valid (Out_valid),
    .Out_re    (Out_re),
    .Out_im    (Out_im),
    .Out_idx   (Out_idx),
    .Out_last  (Out_last)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int re;
    int im;
    int idx;
    int last;
    int cyc;
  } obs_t;

  typedef struct {
    int in_re;
    int in_im;
    int exp_re;
    int exp_im;
  } vec_t;

  obs_t obs[$];
  int   exp_re[$];
  int   exp_im[$];
  vec_t tbl[16];
  int   perm[16] = '{0, 8, 4, 12, 2, 10, 6, 14,
                     1, 9, 5, 13, 3, 11, 7, 15};
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  int   k;

  always @(posedge Clk) cyc++;

  always @(negedge Clk) begin
    if (Out_valid) begin
      obs.push_back('{int'(Out_re), int'(Out_im),
                     int'(Out_idx), int'(Out_last), cyc});
    end
  end

  task automatic send(input int re, input int im);
    In_valid = 1'b1;
    In_re    = 13'(re);
    In_im    = 13'(im);
    @(posedge Clk);
    #1;
    In_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input bit ok,
                       input int act, input int req);
    total++;
    if (ok) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, req);
  endtask

  task automatic chk_zero(input string nm);
    total++;
    if (!Out_valid && !Out_last && Out_re == 0 &&
        Out_im == 0 && Out_idx == 0) begin
      passed++;
    end else begin
      $display("FAIL %s: v=%0b l=%0b re=%0d im=%0d idx=%0d, expected all 0",
               nm, Out_valid, Out_last, Out_re, Out_im, Out_idx);
    end
  endtask

  // Output bin j must appear at edge k+1+j, gapless.
  task automatic chk_stream(input string nm, input int kk);
    check({nm, " count"}, obs.size() == exp_re.size(),
          obs.size(), exp_re.size());
    for (int j = 0; j < exp_re.size(); j++) begin
      total++;
      if (j >= obs.size()) begin
        $display("FAIL %s bin %0d: missing, expected re=%0d im=%0d",
                 nm, j, exp_re[j], exp_im[j]);
      end else if (obs[j].re == exp_re[j] && obs[j].im == exp_im[j] &&
                   obs[j].idx == j % 16 &&
                   obs[j].last == int'(j % 16 == 15) &&
                   obs[j].cyc == kk + 1 + j) begin
        passed++;
      end else begin
        $display("FAIL %s bin %0d: got re=%0d im=%0d idx=%0d last=%0d cyc=%0d, expected re=%0d im=%0d idx=%0d last=%0d cyc=%0d",
                 nm, j, obs[j].re, obs[j].im, obs[j].idx, obs[j].last,
                 obs[j].cyc, exp_re[j], exp_im[j], j % 16,
                 int'(j % 16 == 15), kk + 1 + j);
      end
    end
  endtask

  task automatic load_exp(input int base, input int im_sgn);
    for (int j = 0; j < 16; j++) begin
      exp_re.push_back(base + perm[j]);
      exp_im.push_back(im_sgn * (base + perm[j]));
    end
  endtask

  initial begin
    Reset    = 1'b1;
    In_valid = 1'b0;
    In_re    = '0;
    In_im    = '0;
    repeat (2) @(posedge Clk);
    #1;
    chk_zero("reset state");
    @(negedge Clk);
    Reset = 1'b0;
    idle(1);

    // Single continuous frame, table driven
    for (int m = 0; m < 16; m++) begin
      tbl[m] = '{m, -m, perm[m], -perm[m]};
    end
    obs.delete(); exp_re.delete(); exp_im.delete();
    for (int m = 0; m < 16; m++) send(tbl[m].in_re, tbl[m].in_im);
    k = cyc;
    for (int j = 0; j < 16; j++) begin
      exp_re.push_back(tbl[j].exp_re);
      exp_im.push_back(tbl[j].exp_im);
    end
    idle(20);
    chk_stream("single", k);

    // Idle hold after the frame drains
    check("idle valid", Out_valid == 1'b0, Out_valid, 0);
    check("idle last", Out_last == 1'b0, Out_last, 0);
    check("hold re", Out_re == 15, Out_re, 15);
    check("hold im", Out_im == -15, Out_im, -15);
    check("hold idx", Out_idx == 15, Out_idx, 15);

    // Gapped input
    obs.delete(); exp_re.delete(); exp_im.delete();
    for (int m = 0; m < 16; m++) begin
      send(m, -m);
      if (m != 15) idle(1);
    end
    k = cyc;
    load_exp(0, -1);
    idle(20);
    chk_stream("gapped", k);

    // Three back-to-back frames
    obs.delete(); exp_re.delete(); exp_im.delete();
    for (int f = 0; f < 3; f++) begin
      for (int m = 0; m < 16; m++) begin
        send(100 * f + m, -(100 * f + m));
        if (f == 0 && m == 15) k = cyc;
      end
      load_exp(100 * f, -1);
    end
    idle(20);
    chk_stream("b2b", k);

    // Extreme values
    obs.delete(); exp_re.delete(); exp_im.delete();
    for (int m = 0; m < 16; m++) send(-4096, 4095);
    k = cyc;
    for (int j = 0; j < 16; j++) begin
      exp_re.push_back(-4096);
      exp_im.push_back(4095);
    end
    idle(20);
    chk_stream("extreme", k);

    // Reset after 10 inputs of a frame
    for (int m = 0; m < 10; m++) send(50 + m, 60 + m);
    #2;
    Reset = 1'b1;
    #1;
    chk_zero("reset midframe");
    @(negedge Clk);
    Reset = 1'b0;
    idle(1);

    // Reset during a READ
    for (int m = 0; m < 16; m++) send(200 + m, 300 + m);
    idle(6);
    #2;
    Reset = 1'b1;
    #1;
    chk_zero("reset midread");
    obs.delete();
    @(negedge Clk);
    Reset = 1'b0;
    idle(25);
    check("no stale valid", obs.size() == 0, obs.size(), 0);

    // Clean frame after reset starts at wcnt=0
    obs.delete(); exp_re.delete(); exp_im.delete();
    for (int m = 0; m < 16; m++) send(m, -m);
    k = cyc;
    load_exp(0, -1);
    idle(20);
    chk_stream("post reset", k);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
